// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and address helpers for the LBP host-side
// memory responder.
package lbp_pkg;

    localparam int IMG_W        = 128;
    localparam int IMG_PIX      = 16384;
    localparam int INTERIOR_PIX = 15876;
    localparam int PIX_AW       = 14;
    localparam int PIX_DW       = 8;
    localparam int CNT_W        = 15;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Address layout is {row[6:0], col[6:0]}; the outer ring has no LBP code.
    function automatic logic is_border(input logic [PIX_AW-1:0] addr);
        logic [6:0] row;
        logic [6:0] col;
        row = addr[13:7];
        col = addr[6:0];
        return (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    endfunction

endpackage

// File: rtl/lbp_pixel_ram.sv
// 16384x8 pixel store with one synchronous write port and a read port that
// is either combinational or registered, chosen by ASYNC_RD.
module lbp_pixel_ram
    import lbp_pkg::*;
#(
    parameter int ASYNC_RD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PIX_AW-1:0] waddr,
    input  logic [PIX_DW-1:0] wdata,
    input  logic              re,
    input  logic [PIX_AW-1:0] raddr,
    output logic [PIX_DW-1:0] rdata
);

    logic [PIX_DW-1:0] mem [IMG_PIX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (ASYNC_RD != 0) begin : g_async
            // The combinational port needs neither a read enable nor a reset.
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = reset ^ re;
            assign rdata = mem[raddr];
        end else begin : g_sync
            logic [PIX_DW-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/lbp_mem_responder.sv
// Host-side responder: loads a gray image, serves zero-latency engine reads,
// captures LBP writes, checks completeness and offers registered readback.
module lbp_mem_responder
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  wr_count,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  INTERIOR = CNT_W'(INTERIOR_PIX);

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  load_ptr;
    logic [CNT_W-1:0]   count_next;
    logic               err_set;
    logic               gray_we;
    logic               lbp_we;
    logic [ADDR_W-1:0]  lbp_waddr;
    logic [DATA_W-1:0]  lbp_wdata;
    logic               rd_en;
    logic [DATA_W-1:0]  gray_rdata;

    // gray_req carries no information the responder needs; reads are ungated.
    logic unused_gray_req;
    assign unused_gray_req = gray_req;

    always_comb begin
        next_state = state;
        gray_we    = 1'b0;
        lbp_we     = 1'b0;
        lbp_waddr  = load_ptr;
        lbp_wdata  = '0;
        count_next = wr_count;
        err_set    = 1'b0;
        rd_en      = 1'b0;
        case (state)
            LOAD: begin
                // Zeroing the result alongside the load leaves border pixels cleared.
                if (load_valid) begin
                    gray_we = 1'b1;
                    lbp_we  = 1'b1;
                    if (load_ptr == LAST_PIX) begin
                        next_state = SERVE;
                    end
                end
                if (lbp_valid) begin
                    err_set = 1'b1;
                end
            end
            SERVE: begin
                if (lbp_valid) begin
                    lbp_we    = 1'b1;
                    lbp_waddr = lbp_addr;
                    lbp_wdata = lbp_data;
                    if (wr_count != CNT_MAX) begin
                        count_next = wr_count + 1'b1;
                    end
                    if (is_border(lbp_addr)) begin
                        err_set = 1'b1;
                    end
                end
                // A write landing with finish is counted before completeness is judged.
                if (finish) begin
                    next_state = DONE;
                    if (count_next != INTERIOR) begin
                        err_set = 1'b1;
                    end
                end
            end
            DONE: begin
                rd_en = rd_req;
                if (lbp_valid) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            load_ptr <= '0;
            wr_count <= '0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= next_state;
            wr_count <= count_next;
            rd_valid <= rd_en;
            if (gray_we) begin
                load_ptr <= load_ptr + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign gray_ready = (state == SERVE);
    assign done       = (state == DONE);
    assign gray_data  = (state == LOAD) ? '0 : gray_rdata;

    lbp_pixel_ram #(.ASYNC_RD(1)) gray_mem (
        .clk   (clk),
        .reset (reset),
        .we    (gray_we),
        .waddr (load_ptr),
        .wdata (load_data),
        .re    (1'b0),
        .raddr (gray_addr),
        .rdata (gray_rdata)
    );

    lbp_pixel_ram #(.ASYNC_RD(0)) lbp_mem (
        .clk   (clk),
        .reset (reset),
        .we    (lbp_we),
        .waddr (lbp_waddr),
        .wdata (lbp_wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lbp_mem_responder.sv
// Self-checking bench for lbp_mem_responder: table-driven gray reads plus
// multi-cycle load, write, error, reset and scoreboarded readback sequences.
module tb_lbp_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        gray_ready;
    logic        gray_req = 1'b0;
    logic [13:0] gray_addr = '0;
    logic [7:0]  gray_data;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        done;
    logic        err;
    logic [14:0] wr_count;
    logic        rd_req = 1'b0;
    logic [13:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_lbp [16384];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  exp_data;
    } gray_vec_t;

    gray_vec_t gray_vecs [6];

    always #5 clk = ~clk;

    lbp_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .err        (err),
        .wr_count   (wr_count),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] addr);
        @(posedge clk);
        #1;
        gray_req  = 1'b1;
        gray_addr = addr;
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        load_valid = 1'b0;
        lbp_valid  = 1'b0;
        finish     = 1'b0;
        rd_req     = 1'b0;
        gray_req   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset gray_ready", 32'(gray_ready), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset wr_count", 32'(wr_count), 32'd0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    endtask

    task automatic loadImage(input bit pulse_finish);
        logic bad_ready;
        logic bad_gray;
        bad_ready = 1'b0;
        bad_gray  = 1'b0;
        gray_addr = 14'h0289;
        for (int i = 0; i < 16384; i++) begin
            @(posedge clk);
            #1;
            load_valid = 1'b1;
            load_data  = i[7:0];
            finish     = pulse_finish && (i == 100);
            exp_lbp[i] = 8'h00;
            @(negedge clk);
            if (gray_ready !== 1'b0) bad_ready = 1'b1;
            if (gray_data !== 8'h00) bad_gray = 1'b1;
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        finish     = 1'b0;
        @(negedge clk);
        checkOutput("gray_ready low during load", 32'(bad_ready), 32'd0);
        checkOutput("gray_data zero during load", 32'(bad_gray), 32'd0);
        checkOutput("gray_ready after last beat", 32'(gray_ready), 32'd1);
    endtask

    task automatic writeInterior(input bit do_skip, input logic [13:0] skip_addr);
        logic [13:0] a;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                a = {r[6:0], c[6:0]};
                if (do_skip && a == skip_addr) continue;
                @(posedge clk);
                #1;
                lbp_valid  = 1'b1;
                lbp_addr   = a;
                lbp_data   = 8'hA5;
                finish     = (r == 126) && (c == 126);
                exp_lbp[a] = 8'hA5;
            end
        end
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        @(negedge clk);
    endtask

    task automatic readBack(input logic [13:0] addrs [$]);
        logic [7:0] e;
        for (int i = 0; i < addrs.size(); i++) begin
            @(posedge clk);
            #1;
            rd_req  = 1'b1;
            rd_addr = addrs[i];
            exp_q.push_back(exp_lbp[addrs[i]]);
            @(negedge clk);
            if (i == 0) begin
                checkOutput("rd_valid before first result", 32'(rd_valid), 32'd0);
            end else if (rd_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(e));
            end else begin
                checkOutput("rd_valid back-to-back", 32'(rd_valid), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) begin
            @(negedge clk);
            if (rd_valid) begin
                e = exp_q.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(e));
            end
        end
        checkOutput("readback results outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        checkOutput("rd_valid idle", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [13:0] rb_addrs [$];

        gray_vecs[0] = '{14'h0289, 8'h89};
        gray_vecs[1] = '{14'h0000, 8'h00};
        gray_vecs[2] = '{14'h3FFF, 8'hFF};
        gray_vecs[3] = '{14'h0101, 8'h01};
        gray_vecs[4] = '{14'h2A7E, 8'h7E};
        gray_vecs[5] = '{14'h1F40, 8'h40};

        resetDut();

        // Aborted run: border write flags immediately, then reset mid-SERVE.
        loadImage(1'b0);
        @(posedge clk);
        #1;
        lbp_valid = 1'b1;
        lbp_addr  = 14'h007F;
        lbp_data  = 8'h33;
        @(negedge clk);
        checkOutput("err before border write", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        @(negedge clk);
        checkOutput("err after border write", 32'(err), 32'd1);
        checkOutput("wr_count after border write", 32'(wr_count), 32'd1);
        resetDut();

        // Full passing run after reload.
        loadImage(1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(gray_vecs[i].addr);
            checkOutput($sformatf("gray_data[%0h]", gray_vecs[i].addr), 32'(gray_data), 32'(gray_vecs[i].exp_data));
        end
        gray_req = 1'b0;
        @(posedge clk);
        #1;
        rd_req  = 1'b1;
        rd_addr = 14'h0081;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        checkOutput("rd_valid ignored in SERVE", 32'(rd_valid), 32'd0);

        writeInterior(1'b0, 14'h0000);
        checkOutput("wr_count full run", 32'(wr_count), 32'd15876);
        checkOutput("done full run", 32'(done), 32'd1);
        checkOutput("err full run", 32'(err), 32'd0);
        checkOutput("gray_ready in DONE", 32'(gray_ready), 32'd0);

        rb_addrs = '{14'h0000, 14'h0081, 14'h3FFF, 14'h1F40, 14'h0081};
        readBack(rb_addrs);

        @(posedge clk);
        #1;
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0081;
        lbp_data  = 8'h11;
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        @(negedge clk);
        checkOutput("err on write in DONE", 32'(err), 32'd1);
        checkOutput("done held", 32'(done), 32'd1);
        rb_addrs = '{14'h0081};
        readBack(rb_addrs);

        // Incomplete run: finish pulse during load is ignored, one write missing.
        resetDut();
        loadImage(1'b1);
        writeInterior(1'b1, {7'd60, 7'd60});
        checkOutput("wr_count missing run", 32'(wr_count), 32'd15875);
        checkOutput("err missing run", 32'(err), 32'd1);
        checkOutput("done missing run", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lbp_mem_responder.md
Name: lbp_mem_responder

Overview:
- Host-side responder for the LBP engine's gray-read and lbp-write interface.
- Accepts a preloaded 128x128 8-bit grayscale image from a raster stream.
- Raises gray_ready, then serves gray_req/gray_addr reads with zero-cycle latency.
- Captures lbp_valid/lbp_addr/lbp_data writes into a result image, checks completion on finish, and exposes the result through a registered readback port.

Parameters:
- IMG_W, 128, image width and height in pixels.
- ADDR_W, 14, pixel address width; address is {row[6:0], col[6:0]}.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load stream beat valid
- load_data  in  8  gray pixel, raster order starting at address 0
- gray_ready  out  1  image loaded; engine may start
- gray_req  in  1  engine read request
- gray_addr  in  14  engine read address
- gray_data  out  8  pixel at gray_addr
- lbp_valid  in  1  engine write strobe
- lbp_addr  in  14  engine write address
- lbp_data  in  8  LBP code
- finish  in  1  engine completion
- done  out  1  run complete; readback enabled
- err  out  1  sticky protocol or completeness error
- wr_count  out  15  accepted LBP writes
- rd_req  in  1  readback request
- rd_addr  in  14  readback address
- rd_data  out  8  result pixel
- rd_valid  out  1  rd_data valid

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clk. It puts the block in LOAD and clears load_ptr, gray_ready, done, err, wr_count, rd_data and rd_valid to 0.
- Reset does not clear the memory arrays. Reset mid-run aborts the run, and a full reload is required.
- FSM states are LOAD, SERVE and DONE.
- LOAD:
  - On each load_valid: gray_mem[load_ptr] <= load_data, lbp_mem[load_ptr] <= 0, and load_ptr increments.
  - The zero write pre-clears border pixels of the result image.
  - On load_valid with load_ptr == 16383, the next state is SERVE. gray_ready goes to 1 on the following cycle.
  - gray_data is forced to 0 in LOAD.
- SERVE:
  - gray_ready holds at 1.
  - gray_data = gray_mem[gray_addr] is an asynchronous, combinational read. This is mandatory: the engine registers gray_addr and samples gray_data on the very next edge.
  - The read is not gated by gray_req. gray_req is monitored only.
  - On lbp_valid: lbp_mem[lbp_addr] <= lbp_data and wr_count increments (saturating at 32767).
  - If lbp_addr is a border address (row or col equal to 0 or 127), the write still occurs and err is set.
  - On finish, the next state is DONE: done=1 and gray_ready=0 on the following cycle.
  - Completeness is checked using the post-increment count, so an lbp_valid in the same cycle as finish is written and counted first. If that count != 15876 (126*126), err is set.
- DONE:
  - rd_req causes rd_data <= lbp_mem[rd_addr] and rd_valid <= 1 one cycle later. Without rd_req, rd_valid = 0.
  - Back-to-back requests give one result per cycle.
  - DONE is held until reset.
- Ignored inputs:
  - load_valid outside LOAD is ignored.
  - rd_req outside DONE is ignored.
- Errors:
  - lbp_valid outside SERVE sets err and performs no write.
  - finish outside SERVE is ignored.
- Addresses are unsigned 14-bit and load_ptr wraps only by the state change. No arithmetic is applied to pixel data.

Decomposition:
- Package lbp_pkg holds:
  - IMG_W, IMG_PIX = 16384, INTERIOR_PIX = 15876;
  - the state encoding LOAD/SERVE/DONE;
  - an is_border(addr) function.
- One natural sub-module, lbp_pixel_ram: a 16384x8 array with a synchronous write port and parameter ASYNC_RD selecting combinational or registered read. It is instantiated twice: gray_mem with ASYNC_RD=1 and lbp_mem with ASYNC_RD=0.

Test Plan:
- Stream 16384 beats with load_data = addr[7:0] -> gray_ready=0 throughout, gray_ready=1 exactly one cycle after the last beat.
- In SERVE, drive gray_addr = {7'd5, 7'd9} -> gray_data = 8'h89 in the same cycle; change to 0x0000 -> 8'h00 in the same cycle.
- Write all 15876 interior addresses with lbp_data = 8'hA5, the last write coinciding with finish -> wr_count = 15876, done=1, err=0.
- Same run with one write missing -> err=1 after finish; separately, lbp_valid at lbp_addr 0x007F -> err=1 immediately.
- Readback rd_addr 0x0000 then 0x0081 on consecutive cycles -> rd_data 8'h00 then 8'hA5 on the next two cycles, rd_valid high for both.
- Assert reset mid-SERVE, then reload -> state LOAD, gray_ready=0, wr_count=0, err=0; a second full run passes.
